// File: rtl/z_isa_pkg.sv
// Shared MIPS ISA constants: opcodes, instruction field positions and the
// operand-B selection decoder used by decode, and later by z_ALU and control.
package z_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    B_REG,
    B_SEXT,
    B_ZEXT,
    B_ILLEGAL
  } b_sel_e;

  // Anything not listed here is an unsupported opcode and becomes a NOP.
  function automatic b_sel_e decode_b_sel(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE: decode_b_sel = B_REG;
      OP_ADDIU, OP_LW, OP_SW:   decode_b_sel = B_SEXT;
      OP_ANDI:                  decode_b_sel = B_ZEXT;
      default:                  decode_b_sel = B_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/z_regfile.sv
// 32x32 register file: two async read ports, one sync write port, R0 hardwired.
// Define Z_DECODE_BYPASS_EN to forward a same-cycle write to the read ports.
module z_regfile
  import z_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
`ifdef Z_DECODE_BYPASS_EN
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs_addr)) rs_data = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt_addr)) rt_data = wb_data;
`endif
  end

endmodule

// File: rtl/z_decode_stage.sv
// Instruction decode: register read, operand-B mux and the ID/EX register feeding z_ALU.
// Z_DECODE_BYPASS_EN (in z_regfile) forwards same-cycle writeback into the operands.
module z_decode_stage
  import z_isa_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] ins_in,
  input  logic        ins_valid_in,
  output logic        ready_out,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [4:0]  shamt_out,
  output logic [31:0] ins_out,
  output logic        valid_out,
  output logic        illegal_out
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  logic [15:0] imm;
  b_sel_e      b_sel;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] b_mux;
  logic        hold;
  logic        accept;

  z_regfile u_regfile (
    .clk     (clk_in),
    .rst     (rst_in),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wb_en   (wb_en_in),
    .wb_addr (wb_addr_in),
    .wb_data (wb_data_in)
  );

  always_comb begin
    op    = ins_in[OP_MSB:OP_LSB];
    rs    = ins_in[RS_MSB:RS_LSB];
    rt    = ins_in[RT_MSB:RT_LSB];
    shamt = ins_in[SHAMT_MSB:SHAMT_LSB];
    imm   = ins_in[IMM_MSB:IMM_LSB];
    b_sel = decode_b_sel(op);
    case (b_sel)
      B_REG:   b_mux = rt_data;
      B_SEXT:  b_mux = {{16{imm[15]}}, imm};
      B_ZEXT:  b_mux = {16'h0000, imm};
      default: b_mux = '0;
    endcase
  end

  assign hold      = valid_out && stall_in;
  assign ready_out = !hold;
  assign accept    = ins_valid_in && ready_out;

  // Priority: reset > flush > hold > load > bubble. A held entry never re-reads the register file.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      a_out       <= '0;
      b_out       <= '0;
      shamt_out   <= '0;
      ins_out     <= '0;
      valid_out   <= 1'b0;
      illegal_out <= 1'b0;
    end else if (hold) begin
      a_out       <= a_out;
      b_out       <= b_out;
      shamt_out   <= shamt_out;
      ins_out     <= ins_out;
      valid_out   <= valid_out;
      illegal_out <= illegal_out;
    end else if (accept) begin
      valid_out <= 1'b1;
      if (b_sel == B_ILLEGAL) begin
        a_out       <= '0;
        b_out       <= '0;
        shamt_out   <= '0;
        ins_out     <= '0;
        illegal_out <= 1'b1;
      end else begin
        a_out       <= rs_data;
        b_out       <= b_mux;
        shamt_out   <= (op == OP_RTYPE) ? shamt : 5'd0;
        ins_out     <= ins_in;
        illegal_out <= 1'b0;
      end
    end else begin
      a_out       <= '0;
      b_out       <= '0;
      shamt_out   <= '0;
      ins_out     <= '0;
      valid_out   <= 1'b0;
      illegal_out <= 1'b0;
    end
  end

endmodule
